// File: rtl/ffcp_rx_reorder_pkg.sv
// Shared FFCP constants, write-FSM states and window helper for the RX reorder buffer.
package ffcp_rx_reorder_pkg;

  localparam int unsigned FFCP_INDEX_LEN      = 6;
  localparam int unsigned FFCP_DATA_LEN       = 769;
  localparam int unsigned FFCP_WINDOW_LEN     = 8;
  localparam int unsigned FFCP_RX_SLOT_CNT    = 8;
  localparam int unsigned FFCP_RX_RAM_LATENCY = 2;
  localparam int unsigned FFCP_RX_BYTE_CNT_W  = 10;

  localparam logic [1:0] FFCP_TYPE_ACK = 2'd0;
  localparam logic [1:0] FFCP_TYPE_SYN = 2'd1;
  localparam logic [1:0] FFCP_TYPE_MSG = 2'd2;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_WRITE   = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_e;

  // Distance of an index ahead of the head, modulo the index space.
  function automatic logic [FFCP_INDEX_LEN-1:0] ffcp_idx_offset(
    input logic [FFCP_INDEX_LEN-1:0] idx,
    input logic [FFCP_INDEX_LEN-1:0] head
  );
    return idx - head;
  endfunction

endpackage

// File: rtl/ffcp_rx_reorder_bram_sdp_byte.sv
// Simple dual-port byte RAM with a RAM_LATENCY-deep, flushable read pipeline.
module ffcp_rx_reorder_bram_sdp_byte #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned RAM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];
  logic [7:0] pipe_q [RAM_LATENCY];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Idle read slots carry zero so the pipeline tail is a clean output byte.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int i = 0; i < int'(RAM_LATENCY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= rd_en_i ? mem[rd_addr_i] : 8'd0;
      for (int i = 1; i < int'(RAM_LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rd_data_o = pipe_q[RAM_LATENCY-1];

endmodule

// File: rtl/ffcp_rx_reorder.sv
// FFCP receive reorder buffer: stores in-window packets per slot, drains in index order.
// Optional drop statistics when FFCP_RX_REORDER_STATS_EN is defined.
module ffcp_rx_reorder
  import ffcp_rx_reorder_pkg::*;
#(
  parameter int unsigned SLOT_CNT    = FFCP_RX_SLOT_CNT,
  parameter int unsigned DATA_LEN    = FFCP_DATA_LEN,
  parameter int unsigned RAM_LATENCY = FFCP_RX_RAM_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      metadata_inclk,
  input  logic [1:0]                in_type,
  input  logic [FFCP_INDEX_LEN-1:0] in_index,
  input  logic                      inclk,
  input  logic [7:0]                in,
  input  logic                      in_done,
  input  logic                      readclk,
  output logic                      out_rdy,
  output logic                      outclk,
  output logic [7:0]                out,
  output logic                      out_done,
  output logic [FFCP_INDEX_LEN-1:0] head_index,
  output logic [15:0]               drop_cnt
);

  localparam int unsigned SLOT_W = $clog2(SLOT_CNT);
  localparam int unsigned IDX_W  = FFCP_INDEX_LEN;
  localparam int unsigned CNT_W  = FFCP_RX_BYTE_CNT_W;
  localparam int unsigned ADDR_W = SLOT_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_LEN - 1);

  wr_state_e            state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [IDX_W-1:0]     head_q, head_d;
  logic [SLOT_CNT-1:0]  valid_q, valid_d;
  logic                 out_rdy_q, out_rdy_d;
  logic [RAM_LATENCY-1:0] oclk_pipe_q, odone_pipe_q;

  logic              meta_syn, meta_msg, msg_ok, wr_full;
  logic              ram_we, rd_fire, rd_last, flush;
  logic [SLOT_W-1:0] in_slot, head_slot;

  assign in_slot   = in_index[SLOT_W-1:0];
  assign head_slot = head_q[SLOT_W-1:0];
  assign meta_syn  = metadata_inclk && (in_type == FFCP_TYPE_SYN);
  assign meta_msg  = metadata_inclk && (in_type == FFCP_TYPE_MSG);
  assign msg_ok    = (32'(ffcp_idx_offset(in_index, head_q)) < SLOT_CNT) && !valid_q[in_slot];
  assign wr_full   = inclk && (wr_cnt_q == LAST_BYTE);

  // Write FSM plus read-side bookkeeping; a SYN overrides everything on the read side.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    head_d   = head_q;
    valid_d  = valid_q;
    ram_we   = 1'b0;
    rd_fire  = 1'b0;
    rd_last  = 1'b0;
    flush    = 1'b0;

    if (readclk && out_rdy_q && !meta_syn) begin
      rd_fire = 1'b1;
      rd_last = (rd_cnt_q == LAST_BYTE);
      if (rd_last) begin
        valid_d[head_slot] = 1'b0;
        head_d             = head_q + IDX_W'(1);
        rd_cnt_d           = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end
    end

    if (meta_syn) begin
      head_d   = '0;
      valid_d  = '0;
      rd_cnt_d = '0;
      flush    = 1'b1;
      slot_d   = '0;
      wr_cnt_d = '0;
      state_d  = WR_WRITE;
    end else if (meta_msg) begin
      if (msg_ok) begin
        slot_d   = in_slot;
        wr_cnt_d = '0;
        state_d  = WR_WRITE;
      end else begin
        state_d = WR_DISCARD;
      end
    end else if (!metadata_inclk) begin
      case (state_q)
        WR_WRITE: begin
          if (inclk) begin
            ram_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
          if (in_done) begin
            if (wr_full) begin
              valid_d[slot_q] = 1'b1;
            end
            state_d = WR_IDLE;
          end
        end
        WR_DISCARD: begin
          if (in_done) begin
            state_d = WR_IDLE;
          end
        end
        WR_IDLE: ;
        default: state_d = WR_IDLE;
      endcase
    end

    out_rdy_d = valid_d[head_d[SLOT_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WR_IDLE;
      slot_q    <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      head_q    <= '0;
      valid_q   <= '0;
      out_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      head_q    <= head_d;
      valid_q   <= valid_d;
      out_rdy_q <= out_rdy_d;
    end
  end

  // Strobes travel alongside the RAM read so they line up with the data byte.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      oclk_pipe_q  <= '0;
      odone_pipe_q <= '0;
    end else begin
      oclk_pipe_q[0]  <= rd_fire;
      odone_pipe_q[0] <= rd_fire && rd_last;
      for (int i = 1; i < int'(RAM_LATENCY); i++) begin
        oclk_pipe_q[i]  <= oclk_pipe_q[i-1];
        odone_pipe_q[i] <= odone_pipe_q[i-1];
      end
    end
  end

  ffcp_rx_reorder_bram_sdp_byte #(
    .ADDR_W      (ADDR_W),
    .RAM_LATENCY (RAM_LATENCY)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .wr_en_i   (ram_we),
    .wr_addr_i ({slot_q, wr_cnt_q}),
    .wr_data_i (in),
    .rd_en_i   (rd_fire),
    .rd_addr_i ({head_slot, rd_cnt_q}),
    .rd_data_o (out)
  );

  assign out_rdy    = out_rdy_q;
  assign outclk     = oclk_pipe_q[RAM_LATENCY-1];
  assign out_done   = odone_pipe_q[RAM_LATENCY-1];
  assign head_index = head_q;

`ifdef FFCP_RX_REORDER_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;
  logic        abandon, reject, trunc;

  // Abandoned-in-flight and rejected-on-arrival can coincide in one metadata cycle.
  always_comb begin
    abandon    = (meta_syn || meta_msg) && (state_q == WR_WRITE);
    reject     = meta_msg && !msg_ok;
    trunc      = !metadata_inclk && (state_q == WR_WRITE) && in_done && !wr_full;
    drop_sum   = 17'(drop_cnt_q) + 17'(abandon) + 17'(reject) + 17'(trunc);
    drop_cnt_d = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ffcp_rx_reorder.sv
// Directed self-checking bench for ffcp_rx_reorder.
module tb_ffcp_rx_reorder;
  import ffcp_rx_reorder_pkg::*;

  localparam int DL = FFCP_DATA_LEN;
  localparam int LAT = FFCP_RX_RAM_LATENCY;
`ifdef FFCP_RX_REORDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk, rst, metadata_inclk, inclk, in_done, readclk;
  logic [1:0] in_type;
  logic [5:0] in_index;
  logic [7:0] din, dout;
  logic       out_rdy, outclk, out_done;
  logic [5:0] head_index;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] got_q[$];
  int done_q[$];

  ffcp_rx_reorder dut (
    .clk(clk), .rst(rst), .metadata_inclk(metadata_inclk), .in_type(in_type),
    .in_index(in_index), .inclk(inclk), .in(din), .in_done(in_done),
    .readclk(readclk), .out_rdy(out_rdy), .outclk(outclk), .out(dout),
    .out_done(out_done), .head_index(head_index), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] seed_of(input int p);
    return 8'(p * 37 + 3);
  endfunction

  function automatic logic [15:0] exp_drop(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  // Number of collected bytes that differ from ramp packets with the given seeds.
  function automatic int count_bad(input logic [7:0] seeds[$]);
    int bad = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      int p = i / DL;
      if (p >= seeds.size()) bad++;
      else if (got_q[i] !== 8'(8'(i % DL) + seeds[p])) bad++;
    end
    return bad;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send_meta(input logic [1:0] t, input logic [5:0] idx);
    metadata_inclk = 1'b1;
    in_type = t;
    in_index = idx;
    tick();
    metadata_inclk = 1'b0;
  endtask

  task automatic send_bytes(input int start, input int n, input logic [7:0] seed, input bit done);
    for (int k = start; k < start + n; k++) begin
      inclk = 1'b1;
      din = 8'(8'(k) + seed);
      in_done = done && (k == start + n - 1);
      tick();
    end
    inclk = 1'b0;
    in_done = 1'b0;
  endtask

  task automatic send_pkt(input logic [1:0] t, input logic [5:0] idx, input logic [7:0] seed);
    send_meta(t, idx);
    send_bytes(0, DL, seed, 1'b1);
  endtask

  task automatic collect(input int n, input int budget);
    int cyc = 0;
    got_q.delete();
    done_q.delete();
    readclk = 1'b1;
    while (got_q.size() < n && cyc < budget) begin
      tick();
      if (outclk) begin
        got_q.push_back(dout);
        if (out_done) done_q.push_back(got_q.size() - 1);
      end
      cyc++;
    end
    readclk = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++; if (outclk !== 1'b0 || out !== 8'd0) begin n_fail++; $display("FAIL reset_during_out: outclk=%b out=%h required 0/00", outclk, dout); end
    rst = 1'b0;
    tick();
    n_checks++; if (out_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_out_rdy: got %b required 0", out_rdy); end
    n_checks++; if (outclk !== 1'b0 || out_done !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: outclk=%b out_done=%b required 0", outclk, out_done); end
    n_checks++; if (dout !== 8'd0) begin n_fail++; $display("FAIL reset_out: got %h required 00", dout); end
    n_checks++; if (head_index !== 6'd0) begin n_fail++; $display("FAIL reset_head: got %0d required 0", head_index); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d required 0", drop_cnt); end
  endtask

  logic out;
  assign out = |dout;

  task automatic test_in_order();
    logic [7:0] sd[$];
    bit ok;
    do_reset();
    send_pkt(FFCP_TYPE_SYN, 6'd0, 8'h00);
    send_pkt(FFCP_TYPE_MSG, 6'd1, 8'h55);
    n_checks++; if (out_rdy !== 1'b1) begin n_fail++; $display("FAIL in_order_rdy: got %b required 1", out_rdy); end
    collect(2 * DL, 4 * DL);
    sd.push_back(8'h00); sd.push_back(8'h55);
    n_checks++; if (got_q.size() !== 2 * DL) begin n_fail++; $display("FAIL in_order_count: got %0d required %0d", got_q.size(), 2 * DL); end
    n_checks++; if (count_bad(sd) !== 0) begin n_fail++; $display("FAIL in_order_data: %0d bad bytes required 0", count_bad(sd)); end
    ok = (done_q.size() == 2);
    if (ok) ok = (done_q[0] == DL - 1) && (done_q[1] == 2 * DL - 1);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL in_order_done: %0d done strobes, required 2 at bytes %0d,%0d", done_q.size(), DL, 2 * DL); end
    repeat (4) tick();
    n_checks++; if (head_index !== 6'd2) begin n_fail++; $display("FAIL in_order_head: got %0d required 2", head_index); end
    n_checks++; if (out_rdy !== 1'b0 || outclk !== 1'b0) begin n_fail++; $display("FAIL in_order_idle: out_rdy=%b outclk=%b required 0", out_rdy, outclk); end
  endtask

  // Continues from head_index 2 left by test_in_order.
  task automatic test_window();
    logic [7:0] sd[$];
    send_pkt(FFCP_TYPE_MSG, 6'd10, 8'h77);
    n_checks++; if (out_rdy !== 1'b0 || head_index !== 6'd2) begin n_fail++; $display("FAIL window_reject: out_rdy=%b head=%0d required 0/2", out_rdy, head_index); end
    n_checks++; if (drop_cnt !== exp_drop(1)) begin n_fail++; $display("FAIL window_drop: got %0d required %0d", drop_cnt, exp_drop(1)); end
    send_pkt(FFCP_TYPE_MSG, 6'd2, 8'h21);
    n_checks++; if (out_rdy !== 1'b1) begin n_fail++; $display("FAIL window_accept: out_rdy=%b required 1", out_rdy); end
    send_pkt(FFCP_TYPE_MSG, 6'd2, 8'h99);
    n_checks++; if (drop_cnt !== exp_drop(2)) begin n_fail++; $display("FAIL window_dup_drop: got %0d required %0d", drop_cnt, exp_drop(2)); end
    collect(DL, 2 * DL);
    sd.push_back(8'h21);
    n_checks++; if (got_q.size() !== DL || count_bad(sd) !== 0) begin n_fail++; $display("FAIL window_dup_data: %0d bytes, %0d bad, required %0d/0", got_q.size(), count_bad(sd), DL); end
    repeat (4) tick();
    n_checks++; if (head_index !== 6'd3) begin n_fail++; $display("FAIL window_head: got %0d required 3", head_index); end
  endtask

  task automatic test_out_of_order();
    logic [7:0] sd[$];
    bit ok;
    do_reset();
    send_meta(FFCP_TYPE_SYN, 6'd0);
    send_bytes(0, DL - 1, 8'h40, 1'b0);
    n_checks++; if (out_rdy !== 1'b0) begin n_fail++; $display("FAIL ooo_rdy_early: got %b required 0", out_rdy); end
    send_bytes(DL - 1, 1, 8'h40, 1'b1);
    n_checks++; if (out_rdy !== 1'b1) begin n_fail++; $display("FAIL ooo_rdy_after_syn: got %b required 1", out_rdy); end
    send_pkt(FFCP_TYPE_MSG, 6'd3, 8'h43);
    send_pkt(FFCP_TYPE_MSG, 6'd2, 8'h42);
    send_pkt(FFCP_TYPE_MSG, 6'd1, 8'h41);
    collect(4 * DL, 8 * DL);
    sd.push_back(8'h40); sd.push_back(8'h41); sd.push_back(8'h42); sd.push_back(8'h43);
    n_checks++; if (got_q.size() !== 4 * DL) begin n_fail++; $display("FAIL ooo_count: got %0d required %0d", got_q.size(), 4 * DL); end
    n_checks++; if (count_bad(sd) !== 0) begin n_fail++; $display("FAIL ooo_order: %0d bad bytes required 0", count_bad(sd)); end
    ok = (done_q.size() == 4);
    if (ok) ok = (done_q[3] == 4 * DL - 1);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ooo_done: %0d done strobes required 4", done_q.size()); end
    repeat (4) tick();
    n_checks++; if (head_index !== 6'd4 || out_rdy !== 1'b0) begin n_fail++; $display("FAIL ooo_head: head=%0d out_rdy=%b required 4/0", head_index, out_rdy); end
  endtask

  task automatic test_truncate();
    logic [7:0] sd[$];
    do_reset();
    send_pkt(FFCP_TYPE_SYN, 6'd0, 8'hA0);
    send_meta(FFCP_TYPE_MSG, 6'd1);
    send_bytes(0, 100, 8'h11, 1'b0);
    send_pkt(FFCP_TYPE_MSG, 6'd2, 8'hC0);
    n_checks++; if (drop_cnt !== exp_drop(1)) begin n_fail++; $display("FAIL trunc_drop: got %0d required %0d", drop_cnt, exp_drop(1)); end
    collect(DL, 2 * DL);
    sd.push_back(8'hA0);
    n_checks++; if (got_q.size() !== DL || count_bad(sd) !== 0) begin n_fail++; $display("FAIL trunc_first: %0d bytes, %0d bad, required %0d/0", got_q.size(), count_bad(sd), DL); end
    repeat (4) tick();
    n_checks++; if (head_index !== 6'd1 || out_rdy !== 1'b0) begin n_fail++; $display("FAIL trunc_slot1: head=%0d out_rdy=%b required 1/0", head_index, out_rdy); end
    send_pkt(FFCP_TYPE_MSG, 6'd1, 8'hB0);
    collect(2 * DL, 4 * DL);
    sd.delete(); sd.push_back(8'hB0); sd.push_back(8'hC0);
    n_checks++; if (got_q.size() !== 2 * DL || count_bad(sd) !== 0) begin n_fail++; $display("FAIL trunc_rest: %0d bytes, %0d bad, required %0d/0", got_q.size(), count_bad(sd), 2 * DL); end
    repeat (4) tick();
    n_checks++; if (head_index !== 6'd3 || drop_cnt !== exp_drop(1)) begin n_fail++; $display("FAIL trunc_end: head=%0d drop=%0d required 3/%0d", head_index, drop_cnt, exp_drop(1)); end
  endtask

  task automatic test_syn_mid_drain();
    logic [7:0] sd[$];
    int extra = 0;
    int cyc = 0;
    do_reset();
    send_pkt(FFCP_TYPE_SYN, 6'd0, 8'h10);
    send_pkt(FFCP_TYPE_MSG, 6'd1, 8'h20);
    got_q.delete();
    readclk = 1'b1;
    while (got_q.size() < DL + 300 && cyc < 3 * DL) begin
      tick();
      if (outclk) got_q.push_back(dout);
      cyc++;
    end
    n_checks++; if (got_q.size() !== DL + 300 || head_index !== 6'd1) begin n_fail++; $display("FAIL syn_pre: %0d bytes head=%0d required %0d/1", got_q.size(), head_index, DL + 300); end
    send_meta(FFCP_TYPE_SYN, 6'd0);
    if (outclk) extra++;
    repeat (LAT + 2) begin
      tick();
      if (outclk) extra++;
    end
    readclk = 1'b0;
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL syn_stop: %0d bytes after SYN required 0", extra); end
    n_checks++; if (head_index !== 6'd0 || out_rdy !== 1'b0) begin n_fail++; $display("FAIL syn_head: head=%0d out_rdy=%b required 0/0", head_index, out_rdy); end
    send_bytes(0, DL, 8'h30, 1'b1);
    collect(DL, 2 * DL);
    sd.push_back(8'h30);
    n_checks++; if (got_q.size() !== DL || count_bad(sd) !== 0) begin n_fail++; $display("FAIL syn_new_data: %0d bytes, %0d bad, required %0d/0", got_q.size(), count_bad(sd), DL); end
    n_checks++; if (done_q.size() !== 1) begin n_fail++; $display("FAIL syn_new_done: %0d done strobes required 1", done_q.size()); end
    repeat (4) tick();
    n_checks++; if (head_index !== 6'd1) begin n_fail++; $display("FAIL syn_new_head: got %0d required 1", head_index); end
  endtask

  task automatic test_wrap();
    logic [7:0] sd[$];
    localparam int NPKT = 66;
    do_reset();
    fork
      begin
        send_pkt(FFCP_TYPE_SYN, 6'd0, seed_of(0));
        for (int p = 1; p < NPKT; p++) send_pkt(FFCP_TYPE_MSG, 6'(p), seed_of(p));
      end
      collect(NPKT * DL, 60000);
    join
    for (int p = 0; p < NPKT; p++) sd.push_back(seed_of(p));
    n_checks++; if (got_q.size() !== NPKT * DL) begin n_fail++; $display("FAIL wrap_count: got %0d required %0d", got_q.size(), NPKT * DL); end
    n_checks++; if (count_bad(sd) !== 0) begin n_fail++; $display("FAIL wrap_data: %0d bad bytes required 0", count_bad(sd)); end
    n_checks++; if (done_q.size() !== NPKT) begin n_fail++; $display("FAIL wrap_done: got %0d required %0d", done_q.size(), NPKT); end
    repeat (4) tick();
    n_checks++; if (head_index !== 6'd2 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL wrap_head: head=%0d drop=%0d required 2/0", head_index, drop_cnt); end
  endtask

  initial begin
    rst = 1'b0; metadata_inclk = 1'b0; in_type = 2'd0; in_index = 6'd0;
    inclk = 1'b0; din = 8'd0; in_done = 1'b0; readclk = 1'b0;
    tick();
    test_reset();
    test_in_order();
    test_window();
    test_out_of_order();
    test_truncate();
    test_syn_mid_drain();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ffcp_rx_reorder.md
Name: ffcp_rx_reorder

Overview:
- Receive-side packet buffer for FFCP, sitting between ffcp_rx and the downstream FGP consumer.
- Stores in-window msg/syn payloads into per-index slots, whatever order they arrive in.
- Drains complete slots strictly in index order through a pull (readclk) interface.
- Exports the next expected index so the ack side can track progress.

Parameters:
- SLOT_CNT, 8: slots held. Power of 2, >= FFCP_WINDOW_LEN, <= 64.
- DATA_LEN, 769: payload bytes per packet (FFCP_DATA_LEN).
- RAM_LATENCY, 2: read latency of the slot RAM, in cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- metadata_inclk  in  1  metadata strobe from ffcp_rx.
- in_type  in  2  FFCP type; valid with metadata_inclk.
- in_index  in  6  FFCP index; valid with metadata_inclk.
- inclk  in  1  payload byte strobe.
- in  in  8  payload byte.
- in_done  in  1  strobe coincident with the last payload byte.
- readclk  in  1  downstream pull request.
- out_rdy  out  1  head slot complete and drainable.
- outclk  out  1  output byte valid.
- out  out  8  output byte.
- out_done  out  1  coincident with the last byte of a packet.
- head_index  out  6  next expected FFCP index.
- drop_cnt  out  16  dropped-packet count (see Optional Feature).

Behaviour:
- Reset: one clock; rst is synchronous and active-high.
  - On rst: head_index=0, all valid bits clear, write state IDLE, read counter 0, delay pipelines flushed.
  - During and after rst: outclk=0, out=0, out_done=0, out_rdy=0, drop_cnt=0.
- Write FSM, IDLE/WRITE/DISCARD, evaluated on metadata_inclk:
  - ACK type: ignored.
  - SYN type: head_index<=0, all valid bits clear, read side aborted (counter 0, pipelines flushed); packet goes to slot 0 -> WRITE.
  - MSG type, accepted: offset=(in_index-head_index) mod 64 < SLOT_CNT and valid[in_index mod SLOT_CNT]==0 -> WRITE.
  - MSG type, otherwise -> DISCARD (drop).
- WRITE:
  - Each inclk writes `in` to RAM address {slot, wr_cnt}, then wr_cnt++.
  - On in_done: set valid[slot], go IDLE.
  - wr_cnt != DATA_LEN-1 at in_done: slot not marked, counts as a drop, go IDLE.
- DISCARD: bytes ignored; in_done -> IDLE.
- metadata_inclk while in WRITE/DISCARD: current packet abandoned (never marked valid), new metadata evaluated normally.
- Read side:
  - out_rdy = valid[head_index mod SLOT_CNT].
  - readclk with out_rdy issues a RAM read at {head slot, rd_cnt}, rd_cnt++.
  - readclk while !out_rdy: ignored.
  - outclk and out follow readclk by exactly RAM_LATENCY cycles.
  - On the read of byte DATA_LEN-1: clear that valid bit, head_index++ (6-bit wrap 63->0), rd_cnt<=0; out_done emerges with that byte.
- Head slot is never rewritten while valid, so a duplicate of the draining packet is dropped.
- Same-cycle valid set (write) and valid clear (read) on different slots: both take effect.
- Window arithmetic is modulo 64 throughout; wrap across 63->0 needs no special casing.
- RAM: SLOT_CNT*1024 bytes; address = {slot, 10-bit byte count}.

Optional Feature:
- Macro: FFCP_RX_REORDER_STATS_EN.
- Defined: drop_cnt counts out-of-window, duplicate and truncated packets; saturates at 16'hFFFF; cleared by rst only (not by SYN).
- Undefined: drop_cnt tied to 0, no counter logic.

Decomposition:
- networking.vh gains:
  - FFCP_TYPE_SYN/MSG/ACK, FFCP_INDEX_LEN, FFCP_DATA_LEN, FFCP_WINDOW_LEN (reused).
  - FFCP_RX_SLOT_CNT.
  - Write FSM state constants.
- One sub-module: bram_sdp_byte, a simple dual-port byte RAM with parameterised depth and RAM_LATENCY.
- The existing delay module carries outclk/out_done alongside the RAM read.

Test Plan:
- SYN idx0 then MSG idx1, each 769 bytes ramp pattern, then continuous readclk -> 1538 outclk bytes in order, out_done at bytes 769 and 1538, head_index=2.
- MSG idx3, idx2, idx1 after SYN idx0 -> out_rdy asserts after idx0 completes; drain order 0,1,2,3; head_index=4.
- head_index=2, MSG idx10 (offset 8 >= SLOT_CNT) -> no write, out_rdy unchanged, drop_cnt=1 with STATS_EN.
- head_index=62, MSG idx63, 0, 1 then drain -> wrap to head_index=2, data intact.
- MSG idx1 truncated after 100 bytes by new metadata idx2 -> slot 1 not valid, idx2 stored; drop_cnt=1.
- SYN arriving mid-drain at byte 300 -> outclk stops within RAM_LATENCY, head_index=0, new packet drains from byte 0.
